// File: rtl/uart_pkg.sv
// Shared UART arbiter definitions: byte width, default stall limit, FSM states.
package uart_pkg;

  localparam int unsigned UART_DATA_W         = 8;
  localparam int unsigned TIMEOUT_CYCLES_DFLT = 27000;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// last+1, wrapping modulo N.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IW = $clog2(N);

  int unsigned cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last) + k) % N;
      if (!found && req[IW'(cand)]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing the UART TX FIFO write port.
// Optional requester-stall timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_DATA_W-1:0]         tx_fifo_data_in,
  output logic                           tx_fifo_write_en,
  input  logic                           tx_fifo_full,
  output logic                           grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           timeout_event
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [IW-1:0]   rr_last_q, rr_last_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            owner_valid;
  logic            owner_xfer;
  logic            stall_expired;

  logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req   (req_valid),
    .last  (rr_last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  assign owner_valid     = req_valid[grant_id_q];
  assign owner_xfer      = (state_q == ARB_BUSY) && owner_valid && !tx_fifo_full;
  assign tx_fifo_data_in = req_bytes[grant_id_q];
  assign grant_valid     = (state_q == ARB_BUSY);
  assign grant_id        = grant_id_q;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 16;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counts only owner-idle cycles; FIFO-full stalls hold the count.
  always_comb begin
    stall_cnt_d   = '0;
    stall_expired = 1'b0;
    if (state_q == ARB_BUSY) begin
      if (!owner_valid) begin
        if (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          stall_expired = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end else if (tx_fifo_full) begin
        stall_cnt_d = stall_cnt_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  assign stall_expired = 1'b0;
`endif

  assign timeout_event = stall_expired;

  always_comb begin
    state_d          = state_q;
    grant_id_d       = grant_id_q;
    rr_last_d        = rr_last_q;
    req_ready        = '0;
    tx_fifo_write_en = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          state_d    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        req_ready[grant_id_q] = !tx_fifo_full;
        tx_fifo_write_en      = owner_xfer;
        if ((owner_xfer && req_last[grant_id_q]) || stall_expired) begin
          state_d   = ARB_IDLE;
          rr_last_d = grant_id_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= '0;
      rr_last_q  <= IW'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_last_q  <= rr_last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter against a message-level round-robin model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 10;
  localparam int unsigned QSZ = 512;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*8-1:0] req_data;
  logic [7:0]     tx_fifo_data_in;
  logic           tx_fifo_write_en, tx_fifo_full, grant_valid, timeout_event;
  logic [1:0]     grant_id;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_last         (req_last),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .tx_fifo_data_in  (tx_fifo_data_in),
    .tx_fifo_write_en (tx_fifo_write_en),
    .tx_fifo_full     (tx_fifo_full),
    .grant_valid      (grant_valid),
    .grant_id         (grant_id),
    .timeout_event    (timeout_event)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       last;
  } xfer_t;

  // Per-requester byte queues: {last, data}
  logic [8:0] mem [N][QSZ];
  int         hd [N];
  int         tl [N];
  xfer_t      exp_q [$];
  int         m_last;
  int         n_vec = 0;
  int         n_err = 0;

  logic           c_we, c_gv, c_tmo, c_full;
  logic [7:0]     c_data;
  logic [1:0]     c_gid;
  logic [N-1:0]   c_rdy, c_acc;

  task automatic present();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (hd[i] != tl[i]);
      req_last[i]        = mem[i][hd[i]][8];
      req_data[i*8 +: 8] = mem[i][hd[i]][7:0];
    end
  endtask

  task automatic push(input int id, input logic [7:0] d, input logic last);
    mem[id][tl[id]] = {last, d};
    tl[id]++;
  endtask

  task automatic push_msg(input int id, input int len);
    for (int j = 0; j < len; j++) push(id, 8'($urandom), j == len - 1);
  endtask

  function automatic bit queues_busy();
    for (int i = 0; i < N; i++) if (hd[i] != tl[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Model: drain all pending messages in round-robin order from m_last+1.
  function automatic void plan();
    int p [N];
    bit any;
    for (int i = 0; i < N; i++) p[i] = hd[i];
    do begin
      any = 1'b0;
      for (int k = 1; k <= N && !any; k++) begin
        int i;
        i = (m_last + k) % N;
        if (p[i] != tl[i]) begin
          bit done;
          any  = 1'b1;
          done = 1'b0;
          while (!done && p[i] != tl[i]) begin
            exp_q.push_back('{id: 2'(i), data: mem[i][p[i]][7:0], last: mem[i][p[i]][8]});
            done = mem[i][p[i]][8];
            p[i]++;
          end
          m_last = i;
        end
      end
    end while (any);
  endfunction

  task automatic step();
    @(negedge clock);
    c_we   = tx_fifo_write_en;
    c_data = tx_fifo_data_in;
    c_gv   = grant_valid;
    c_gid  = grant_id;
    c_tmo  = timeout_event;
    c_rdy  = req_ready;
    c_full = tx_fifo_full;
    c_acc  = req_valid & req_ready;
    for (int i = 0; i < N; i++) if (c_acc[i] === 1'b1) hd[i]++;
    @(posedge clock);
    #1;
    present();
  endtask

  task automatic drain();
    int cyc = 0;
    while ((queues_busy() || grant_valid !== 1'b0) && cyc < 300) begin
      step();
      cyc++;
    end
    exp_q.delete();
    n_vec++;
    if (cyc >= 300) begin
      n_err++;
      $display("FAIL drain: still busy after %0d cycles, required idle", cyc);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    tx_fifo_full = 1'b0;
    present();
    step();
    step();
    n_vec++;
    if (c_gv !== 1'b0 || c_gid !== 2'd0 || c_rdy !== '0 || c_we !== 1'b0 || c_tmo !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: gv=%b gid=%0d rdy=%b we=%b tmo=%b, required all 0",
               c_gv, c_gid, c_rdy, c_we, c_tmo);
    end
    reset  = 1'b0;
    m_last = N - 1;
  endtask

  task automatic test_single();
    push(2, 8'h41, 1'b0);
    push(2, 8'h42, 1'b0);
    push(2, 8'h43, 1'b1);
    present();
    step();
    n_vec++;
    if (c_we !== 1'b0 || c_gv !== 1'b0) begin
      n_err++;
      $display("FAIL single_arb: we=%b gv=%b, required 0 0", c_we, c_gv);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (c_we !== 1'b1 || c_data !== 8'(8'h41 + k) || c_gid !== 2'd2 || c_gv !== 1'b1) begin
        n_err++;
        $display("FAIL single_byte%0d: we=%b data=%02h gid=%0d, required 1 %02h 2",
                 k, c_we, c_data, c_gid, 8'(8'h41 + k));
      end
    end
    step();
    n_vec++;
    if (c_gv !== 1'b0 || c_we !== 1'b0) begin
      n_err++;
      $display("FAIL single_end: gv=%b we=%b, required 0 0", c_gv, c_we);
    end
    m_last = 2;
  endtask

  task automatic test_fairness();
    int    seq [$];
    int    want [4] = '{0, 1, 0, 1};
    int    cyc = 0;
    xfer_t e;
    push_msg(0, 2); push_msg(0, 2);
    push_msg(1, 2); push_msg(1, 2);
    present();
    plan();
    while (exp_q.size() > 0 && cyc < 100) begin
      step();
      cyc++;
      if (c_we === 1'b1) begin
        e = exp_q.pop_front();
        n_vec++;
        if (c_data !== e.data || c_gid !== e.id) begin
          n_err++;
          $display("FAIL fair_byte: id=%0d data=%02h, required id=%0d data=%02h",
                   c_gid, c_data, e.id, e.data);
        end
        if (e.last) seq.push_back(int'(c_gid));
      end
    end
    n_vec++;
    if (seq.size() != 4) begin
      n_err++;
      $display("FAIL fair_count: %0d messages, required 4", seq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (seq[i] != want[i]) begin
          n_err++;
          $display("FAIL fair_order%0d: grant %0d, required %0d", i, seq[i], want[i]);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] b [4];
    for (int j = 0; j < 4; j++) begin
      b[j] = 8'($urandom);
      push(1, b[j], j == 3);
    end
    present();
    step();
    step();
    n_vec++;
    if (c_we !== 1'b1 || c_data !== b[0]) begin
      n_err++;
      $display("FAIL bp_first: we=%b data=%02h, required 1 %02h", c_we, c_data, b[0]);
    end
    tx_fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++;
      if (c_rdy !== '0 || c_we !== 1'b0 || c_gv !== 1'b1) begin
        n_err++;
        $display("FAIL bp_full%0d: rdy=%b we=%b gv=%b, required 0 0 1", k, c_rdy, c_we, c_gv);
      end
    end
    tx_fifo_full = 1'b0;
    for (int j = 1; j < 4; j++) begin
      step();
      n_vec++;
      if (c_we !== 1'b1 || c_data !== b[j] || c_rdy !== 4'b0010) begin
        n_err++;
        $display("FAIL bp_resume%0d: we=%b data=%02h rdy=%b, required 1 %02h 0010",
                 j, c_we, c_data, c_rdy, b[j]);
      end
    end
    step();
    n_vec++;
    if (c_gv !== 1'b0) begin
      n_err++;
      $display("FAIL bp_end: gv=%b, required 0", c_gv);
    end
    m_last = 1;
  endtask

  task automatic test_reset_mid();
    xfer_t e;
    push_msg(3, 3);
    present();
    step();
    step();
    n_vec++;
    if (c_we !== 1'b1 || c_gid !== 2'd3) begin
      n_err++;
      $display("FAIL rmid_first: we=%b gid=%0d, required 1 3", c_we, c_gid);
    end
    reset        = 1'b1;
    tx_fifo_full = 1'b1;
    step();
    reset        = 1'b0;
    tx_fifo_full = 1'b0;
    for (int i = 0; i < N; i++) hd[i] = tl[i];
    m_last = N - 1;
    push_msg(3, 2);
    push_msg(0, 1);
    present();
    plan();
    step();
    n_vec++;
    if (c_gv !== 1'b0 || c_gid !== 2'd0) begin
      n_err++;
      $display("FAIL rmid_after: gv=%b gid=%0d, required 0 0", c_gv, c_gid);
    end
    step();
    e = exp_q.pop_front();
    n_vec++;
    if (c_we !== 1'b1 || c_gid !== 2'd0 || c_data !== e.data) begin
      n_err++;
      $display("FAIL rmid_winner: we=%b gid=%0d data=%02h, required 1 0 %02h",
               c_we, c_gid, c_data, e.data);
    end
    drain();
  endtask

  task automatic test_timeout();
    push(0, 8'h5a, 1'b0);
    push_msg(3, 1);
    present();
    step();
    step();
    n_vec++;
    if (c_we !== 1'b1 || c_gid !== 2'd0 || c_data !== 8'h5a) begin
      n_err++;
      $display("FAIL tmo_first: we=%b gid=%0d data=%02h, required 1 0 5a", c_we, c_gid, c_data);
    end
`ifdef UART_ARB_TIMEOUT_EN
    for (int s = 1; s <= int'(TMO); s++) begin
      step();
      n_vec++;
      if (c_tmo !== (s == int'(TMO)) || c_we !== 1'b0) begin
        n_err++;
        $display("FAIL tmo_stall%0d: tmo=%b we=%b, required %b 0", s, c_tmo, c_we, s == int'(TMO));
      end
    end
    step();
    n_vec++;
    if (c_gv !== 1'b0 || c_tmo !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_idle: gv=%b tmo=%b, required 0 0", c_gv, c_tmo);
    end
    step();
    n_vec++;
    if (c_gv !== 1'b1 || c_gid !== 2'd3 || c_we !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_regrant: gv=%b gid=%0d we=%b, required 1 3 1", c_gv, c_gid, c_we);
    end
`else
    for (int s = 1; s <= 1000; s++) begin
      step();
      n_vec++;
      if (c_gv !== 1'b1 || c_gid !== 2'd0 || c_tmo !== 1'b0 || c_we !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d: gv=%b gid=%0d tmo=%b we=%b, required 1 0 0 0",
                 s, c_gv, c_gid, c_tmo, c_we);
        break;
      end
    end
    push(0, 8'ha5, 1'b1);
    present();
    step();
    n_vec++;
    if (c_we !== 1'b1 || c_data !== 8'ha5 || c_gid !== 2'd0) begin
      n_err++;
      $display("FAIL hold_finish: we=%b data=%02h gid=%0d, required 1 a5 0", c_we, c_data, c_gid);
    end
`endif
    drain();
    m_last = 3;
  endtask

  task automatic test_random();
    xfer_t e;
    logic  prev_last;
    int    cyc;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        int nm;
        nm = int'($urandom_range(0, 6));
        for (int m = 0; m < nm; m++) push_msg(i, int'($urandom_range(1, 4)));
      end
      present();
      plan();
      prev_last = 1'b0;
      cyc       = 0;
      while (exp_q.size() > 0 && cyc < 2000) begin
        tx_fifo_full = ($urandom_range(0, 3) == 0);
        step();
        cyc++;
        n_vec++;
        if ((c_rdy & ~(4'b0001 << c_gid)) !== '0 || (c_full && c_rdy !== '0) ||
            c_we !== (c_acc != '0) || (prev_last && c_we)) begin
          n_err++;
          $display("FAIL rnd_proto: rdy=%b gid=%0d full=%b we=%b prev_last=%b",
                   c_rdy, c_gid, c_full, c_we, prev_last);
        end
        prev_last = 1'b0;
        if (c_we === 1'b1) begin
          e = exp_q.pop_front();
          n_vec++;
          if (c_data !== e.data || c_gid !== e.id) begin
            n_err++;
            $display("FAIL rnd_byte: id=%0d data=%02h, required id=%0d data=%02h",
                     c_gid, c_data, e.id, e.data);
          end
          prev_last = e.last;
        end
      end
      n_vec++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL rnd_stream: %0d bytes unwritten, required 0", exp_q.size());
      end
      tx_fifo_full = 1'b0;
      drain();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
      for (int j = 0; j < int'(QSZ); j++) mem[i][j] = '0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Message-level round-robin arbiter that shares the single UART TX byte FIFO among NUM_REQ independent requesters (command responder, status reporter, debug echo, and so on). It grants the FIFO write port to one requester at a time and holds the grant until that requester marks the last byte of its message, so messages never interleave on the wire. It sits between the requesters and the UART's tx_fifo_data_in, tx_fifo_write_en and tx_fifo_full ports.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 27000: requester-stall limit in clocks, only used under the macro; 1 ms at 27 MHz.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_last  in  NUM_REQ  byte is the last of the message; qualified by req_valid.
- req_data  in  NUM_REQ*8  flattened bytes; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  byte accepted this cycle when valid & ready.
- tx_fifo_data_in  out  8  to the UART TX FIFO.
- tx_fifo_write_en  out  1  to the UART TX FIFO.
- tx_fifo_full  in  1  from the UART TX FIFO.
- grant_valid  out  1  a message is in progress.
- grant_id  out  clog2(NUM_REQ)  current owner.
- timeout_event  out  1  one-cycle pulse when a grant is revoked.

## Operation
- Two states: IDLE and BUSY. A round-robin pointer rr_last holds the index of the most recently granted requester.
- IDLE:
  - All req_ready are 0 and tx_fifo_write_en is 0.
  - If any req_valid is set, pick the first set bit searching upward from rr_last+1, wrapping modulo NUM_REQ.
  - Register the pick into grant_id, set grant_valid, and go to BUSY.
- BUSY:
  - req_ready[grant_id] = !tx_fifo_full. Every other req_ready is 0.
  - tx_fifo_data_in = req_data slice for grant_id, combinational mux.
  - tx_fifo_write_en = req_valid[grant_id] & !tx_fifo_full, combinational.
  - A transfer with req_last set returns the block to IDLE, clears grant_valid, and sets rr_last = grant_id.
- Valid bits of non-owners are ignored during BUSY. They are held, never dropped.
- A requester that deasserts valid mid-message keeps the grant indefinitely, unless the macro is enabled.
- A single-byte message has last=1 on its first byte and is legal.
- Reset:
  - state = IDLE.
  - grant_valid = 0, grant_id = 0, timeout_event = 0.
  - rr_last = NUM_REQ-1, so requester 0 wins first.
  - Reset during BUSY abandons the message. Bytes already written stay in the FIFO.

## Timing
- Arbitration takes 1 cycle: a request seen in IDLE in cycle N gives ready in cycle N+1, provided the FIFO is not full.
- While BUSY, throughput is 1 byte per clock, limited only by tx_fifo_full and req_valid.
- There is one dead IDLE cycle between consecutive messages, including when the same requester continues.
- The FIFO-full to ready path is combinational, so ready drops in the same cycle as full. No byte is written while full.
- tx_fifo_full does not affect the state transitions. Arbitration in IDLE proceeds even while the FIFO is full.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - A 16-bit (or wider, as TIMEOUT_CYCLES requires) stall counter runs in BUSY and increments on cycles where req_valid[grant_id] is 0.
  - The counter clears on every transfer and on entry to BUSY.
  - Cycles stalled only by tx_fifo_full do not count.
  - When the counter reaches TIMEOUT_CYCLES: pulse timeout_event for 1 cycle, go to IDLE, set rr_last = grant_id.
- Macro not defined: no counter exists, and timeout_event is tied to 0. The port list is identical in both builds.

## Structure
- Shared package/header uart_pkg.vh holds:
  - state encodings ARB_IDLE = 1'b0 and ARB_BUSY = 1'b1;
  - the UART byte width constant UART_DATA_W = 8;
  - the default TIMEOUT_CYCLES.
- Sub-module rr_pick: a purely combinational round-robin picker. Inputs are a request vector and rr_last; outputs are a found flag and an index. It is reusable by a future RX dispatcher.
- The top level contains the FSM, the grant registers, the data mux and the optional timeout counter.

## Test plan
- Single requester: req 2 sends 0x41, 0x42, 0x43 with last on 0x43. Expect 3 writes in consecutive cycles starting 1 cycle after valid, in order, followed by grant_valid=0.
- Fairness: reqs 0 and 1 stream continuously, 2-byte messages each. Expect grant_id sequence 0, 1, 0, 1 with no byte interleaving between messages.
- FIFO backpressure: tx_fifo_full high for 5 cycles mid-message. Expect ready=0 and write_en=0 for those 5 cycles, and the held byte written on the first cycle full is low.
- Reset mid-message: assert reset in BUSY after 1 of 3 bytes. Next cycle expect grant_valid=0 and grant_id=0, and requester 0 wins first afterwards.
- Timeout, macro enabled, TIMEOUT_CYCLES=10: the owner stalls after byte 1 while req 3 is valid. Expect timeout_event on stall cycle 10, then req 3 granted 2 cycles later.
- Timeout, macro disabled, same stimulus: the grant holds for 1000 cycles and timeout_event stays 0.
